// File: rtl/conway_window_gen.sv
// Board buffer and 3x3 window generator for a Life cell evaluator.
// Loads one raster-ordered frame, then streams every cell with its 8 neighbours.
module conway_window_gen #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_cell,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_state_0,
  output logic [7:0]    out_neighbors,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [COLS-1:0] r_board [ROWS];

  logic            r_out_valid;
  logic            r_out_state;
  logic [7:0]      r_out_nb;
  logic [RW-1:0]   r_out_row;
  logic [CW-1:0]   r_out_col;
  logic            r_out_last;

  logic            w_in_ready;
  logic            w_in_xfer;
  logic            w_out_acc;
  logic            w_load;
  logic            w_cnt_last;
  logic [7:0]      w_nb;

  assign w_cnt_last = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));
  assign w_in_xfer  = ena && in_valid && (r_state == S_LOAD);
  assign w_out_acc  = ena && r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = ena;
        if (w_in_xfer && w_cnt_last) begin
          w_state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        // Never refill the stage once the final window is sitting in it.
        w_load = ena && (!r_out_valid || out_ready) && !(r_out_valid && r_out_last);
        if (w_out_acc && r_out_last) begin
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

  // Neighbour taps; anything off the board edge reads as dead.
  for (genvar gi = 0; gi < 8; gi++) begin : g_nb
    localparam int DR = (gi < 3) ? -1 : ((gi < 5) ? 0 : 1);
    localparam int DC = (gi == 0 || gi == 3 || gi == 5) ? -1 :
                        ((gi == 1 || gi == 6) ? 0 : 1);
    logic          w_row_ok;
    logic          w_col_ok;
    logic [RW-1:0] w_nr;
    logic [CW-1:0] w_nc;

    assign w_row_ok = (DR < 0) ? (r_row != '0) :
                      ((DR > 0) ? (r_row != RW'(ROWS - 1)) : 1'b1);
    assign w_col_ok = (DC < 0) ? (r_col != '0) :
                      ((DC > 0) ? (r_col != CW'(COLS - 1)) : 1'b1);
    assign w_nr     = r_row + RW'(DR);
    assign w_nc     = r_col + CW'(DC);
    assign w_nb[gi] = w_row_ok && w_col_ok && r_board[w_nr][w_nc];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        r_board[i] <= '0;
      end
    end else if (w_in_xfer) begin
      r_board[r_row][r_col] <= in_cell;
    end
  end

  // Shared raster counter: write address in LOAD, window centre in EMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_in_xfer || w_load) begin
      if (r_col == CW'(COLS - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_state <= 1'b0;
      r_out_nb    <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_state <= r_board[r_row][r_col];
      r_out_nb    <= w_nb;
      r_out_row   <= r_row;
      r_out_col   <= r_col;
      r_out_last  <= w_cnt_last;
    end else if (w_out_acc) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready      = w_in_ready && rst;
  assign out_valid     = r_out_valid && ena;
  assign out_state_0   = r_out_state;
  assign out_neighbors = r_out_nb;
  assign out_row       = r_out_row;
  assign out_col       = r_out_col;
  assign out_last      = r_out_last;

endmodule

// File: tb/tb_conway_window_gen.sv
// Scoreboard bench for conway_window_gen on a 4x4 board.
// Stimulus pushes expected windows; a negedge monitor pops and compares.
module tb_conway_window_gen;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int RW   = 2;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          in_valid;
  logic          in_ready;
  logic          in_cell;
  logic          out_valid;
  logic          out_ready;
  logic          out_state_0;
  logic [7:0]    out_neighbors;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  always #5 clk = ~clk;

  conway_window_gen #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cell      (in_cell),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_state_0  (out_state_0),
    .out_neighbors(out_neighbors),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last)
  );

  typedef struct packed {
    logic       st;
    logic [7:0] nb;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } win_t;

  win_t       sb_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_acc  = 0;
  logic [7:0] cap_nb [16];
  logic       cap_st [16];
  logic       stalled = 1'b0;
  win_t       snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference neighbour vector: bit order NW,N,NE,W,E,SW,S,SE; off-board = 0.
  function automatic logic [7:0] ref_nb(input logic [15:0] b, input int r, input int c);
    logic [7:0] v;
    int dr, dc, rr, cc;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin dr = -1; dc = -1; end
        1: begin dr = -1; dc =  0; end
        2: begin dr = -1; dc =  1; end
        3: begin dr =  0; dc = -1; end
        4: begin dr =  0; dc =  1; end
        5: begin dr =  1; dc = -1; end
        6: begin dr =  1; dc =  0; end
        default: begin dr = 1; dc = 1; end
      endcase
      rr = r + dr;
      cc = c + dc;
      if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) v[k] = b[rr*COLS + cc];
    end
    return v;
  endfunction

  function automatic win_t exp_win(input logic [15:0] b, input int r, input int c);
    win_t w;
    w.st   = b[r*COLS + c];
    w.nb   = ref_nb(b, r, c);
    w.row  = 2'(r);
    w.col  = 2'(c);
    w.last = (r == ROWS-1) && (c == COLS-1);
    return w;
  endfunction

  // Monitor: pops on every accepted window and checks stall stability.
  always @(negedge clk) begin : mon
    win_t cur;
    win_t req;
    cur = win_t'({out_state_0, out_neighbors, out_row, out_col, out_last});
    if (out_valid) begin
      if (stalled) chk("stall_hold", 32'(cur), 32'(snap));
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_window: actual row %0d col %0d, required no window", out_row, out_col);
        end else begin
          req = sb_q.pop_front();
          chk("window", 32'(cur), 32'(req));
          $display("window r%0d c%0d st=%0b nb=%08b last=%0b", out_row, out_col, out_state_0, out_neighbors, out_last);
          cap_nb[{out_row, out_col}] = out_neighbors;
          cap_st[{out_row, out_col}] = out_state_0;
          n_acc++;
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        snap    = cur;
      end
    end else if (ena) begin
      stalled = 1'b0;
    end
  end

  task automatic load_frame(input logic [15:0] bits, input int gap_after);
    int t;
    n_acc = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        sb_q.push_back(exp_win(bits, r, c));
    for (int i = 0; i < ROWS*COLS; i++) begin
      in_valid = 1'b1;
      in_cell  = bits[i];
      if (i == gap_after + 1) begin
        ena = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("load_gap_in_ready", 32'(in_ready), 0);
          chk("load_gap_out_valid", 32'(out_valid), 0);
          @(posedge clk); #1;
        end
        ena = 1'b1;
      end
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        chk("load_in_ready_timeout", 32'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      $display("load cell %0d = %0b", i, bits[i]);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("first_window_latency_0", 32'(out_valid), 0);
    @(negedge clk);
    chk("first_window_latency_1", 32'(out_valid), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_emit(input bit toggle, input int gap_at);
    logic [3:0] rdy_pat;
    int cyc;
    rdy_pat = 4'b1001;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 300) begin
      out_ready = toggle ? rdy_pat[cyc % 4] : 1'b1;
      if (cyc == gap_at) begin
        ena = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("emit_gap_out_valid", 32'(out_valid), 0);
          chk("emit_gap_in_ready", 32'(in_ready), 0);
          @(posedge clk); #1;
        end
        ena = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("emit_drain_timeout", 32'(sb_q.size()), 0);
    out_ready = 1'b1;
    chk("frame_count", 32'(n_acc), 16);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: actual not finished, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    rst       = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_cell   = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_nb", 32'(out_neighbors), 0);
    chk("rst_out_rowcol", 32'({out_row, out_col}), 0);
    chk("rst_out_last", 32'(out_last), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // All-zeros board
    load_frame(16'h0000, -1);
    run_emit(1'b0, -1);

    // Vertical blinker at (0,1),(1,1),(2,1)
    load_frame(16'h0222, -1);
    run_emit(1'b0, -1);
    chk("blink_11_state", 32'(cap_st[5]), 1);
    chk("blink_11_nb", 32'(cap_nb[5]), 32'b0100_0010);
    chk("blink_10_nb", 32'(cap_nb[4]), 32'b1001_0100);
    chk("blink_12_nb", 32'(cap_nb[6]), 32'b0010_1001);

    // All-ones board with ready toggling and an ena gap mid-emit
    load_frame(16'hFFFF, -1);
    run_emit(1'b1, 6);
    chk("ones_corner_nb", 32'(cap_nb[0]), 32'b1101_0000);
    chk("ones_edge_nb", 32'(cap_nb[1]), 32'b1111_1000);
    chk("ones_inner_nb", 32'(cap_nb[5]), 32'hFF);

    // ena gap after cell 5 during load
    load_frame(16'hA5C3, 5);
    run_emit(1'b0, -1);

    // Async reset mid-emit
    load_frame(16'h1234, -1);
    t = 0;
    while (n_acc < 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_5", 32'(n_acc >= 5), 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_state_0", 32'(out_state_0), 0);
    chk("async_nb", 32'(out_neighbors), 0);
    chk("async_rowcol", 32'({out_row, out_col}), 0);
    chk("async_last", 32'(out_last), 0);
    chk("async_in_ready", 32'(in_ready), 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("release_out_valid", 32'(out_valid), 0);
      chk("release_in_ready", 32'(in_ready), 1);
    end
    @(posedge clk); #1;
    load_frame(16'h0F0F, -1);
    run_emit(1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
